raymarch_core: RTL and testbench
================================

# raymarch_core

Parametrised single-sphere ray-march engine that converts one screen pixel into an RGB shade using Q-format fixed-point signed-distance marching. It replaces the earlier fixed-size, free-running raymarcher: the core now has valid/ready handshakes on both sides, configurable fixed-point width, step limit, scene and shading. It also reports hit/miss and step count. It sits between the pixel scheduler (upstream) and the framebuffer writer (downstream) in the pixel clock domain.

## Interface
- WIDTH, 300, screen width in pixels
- HEIGHT, 300, screen height in pixels
- COORD_W, 16, pixel coordinate width
- INT_BITS, 24, integer bits of fixed-point value (signed)
- FRAC_BITS, 8, fraction bits; W = INT_BITS+FRAC_BITS, W+FRAC_BITS must be even
- MAX_STEPS, 64, march iteration limit
- HIT_EPS, 16 (raw, 1/16), hit threshold on SDF
- MAX_DIST, 25600 (raw, 100.0), escape distance on t
- PIX_SCALE, 1 (raw, 1/256), ray slope per pixel offset
- SPH_X/SPH_Y/SPH_Z, 0/0/1280 (raw), sphere centre; SPH_R, 256 (raw, 1.0)
- SHADE_SHIFT, 4, step-count shading shift
- BG_R/BG_G/BG_B, 0/0/0, miss colour
- clk_pixel_in  in  1  pixel clock
- rst_n_in  in  1  reset, asynchronous, active-low
- in_valid  in  1  pixel request valid
- in_ready  out  1  core idle, request accepted when in_valid && in_ready
- curr_x, curr_y  in  COORD_W  pixel coordinates
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_x, out_y  out  COORD_W  coordinates of the result pixel
- red_out, green_out, blue_out  out  8  colour
- hit_out  out  1  ray hit sphere
- steps_out  out  $clog2(MAX_STEPS+1)  iterations evaluated

## Operation
- Camera at origin. Direction d = ((x−WIDTH/2)·PIX_SCALE, (y−HEIGHT/2)·PIX_SCALE, 1.0) in Q(INT.FRAC). PIX_SCALE is chosen so that |dx|,|dy| ≤ 1.0, giving |d| < 2.
- States: IDLE → SETUP → SQ → SQRT → STEP → (SQ | DONE) → IDLE.
- IDLE: in_ready=1. On accept, latch x, y, then go to SETUP.
- SETUP: compute d; p=0, t=0, steps=0.
- SQ: magsq = Σ(p−c)² using fixed-point multiply (product >>> FRAC_BITS), saturating at the signed max. Start fx_sqrt.
- SQRT: wait for fx_sqrt done. sdf = sqrt − SPH_R.
- STEP: steps++.
  - sdf < HIT_EPS → hit, DONE.
  - Otherwise p += (d·sdf)>>>1 and t += sdf>>>1, both saturating. The conservative half step never overshoots.
  - t > MAX_DIST or steps == MAX_STEPS → miss, DONE.
  - Else SQ.
- DONE: out_valid=1 with all result fields stable. Hold until out_ready, then go to IDLE.
- Shade on hit: s = 255 − (steps<<SHADE_SHIFT), clamped to 0; red=green=blue=s. On miss: BG colour.

## Timing
- Reset values: in_ready=0 while reset is asserted, 1 on the first cycle after reset is released. out_valid=0, all data outputs=0, state=IDLE.
- Iteration length L = (W+FRAC_BITS)/2 + 3 cycles: SQ 1 + SQRT (W+FRAC_BITS)/2 + 1 + STEP 1.
- Latency from accept edge to out_valid = 1 + steps·L cycles. With defaults, L=23.
- in_ready is low from the accept cycle until the DONE→IDLE transition. There is no request overlap.
- out_valid stays asserted under backpressure, and outputs do not change while waiting.
- A new request is first acceptable the cycle after out_valid && out_ready.
- Reset mid-march aborts immediately: no out_valid pulse, and fx_sqrt is reset.

## Structure
- raymarch_pkg contains:
  - the fixed-point typedef fx_t [W-1:0]
  - the state enum
  - functions fx_mul and fx_add_sat, and the HIT/DIST constants helpers
- Sub-module fx_sqrt: iterative restoring integer sqrt of (magsq<<FRAC_BITS), one result bit per cycle.
  - Interface: start/done handshake.
  - Exact on perfect squares.

## Test plan
- Default params, pixel (150,150), out_ready=1 → out_valid after 1+8·23=185 cycles; hit_out=1, steps_out=8, rgb=127/127/127, out_x/out_y=150/150.
- Pixel (0,0) → hit_out=0, rgb=0/0/0, steps_out ≤ 64, and t exceeds MAX_DIST or the step limit is reached.
- Backpressure: out_ready=0 for 50 cycles after result → out_valid stays high, fields constant, in_ready=0. Result transfers on the first cycle out_ready=1; in_ready=1 the next cycle.
- Back-to-back: ten centre-pixel requests with in_valid held high → ten results in order, each 185 cycles of latency, with exactly one cycle of IDLE between them.
- Reset pulse (rst_n_in low for 3 cycles) 100 cycles into a march → out_valid never asserts. After release, in_ready=1 and a fresh request completes normally.
- MAX_STEPS=4, centre pixel → hit_out=0, steps_out=4, BG colour.

Source files
------------

// File: rtl/raymarch_pkg.sv
// Shared types and fixed-point helpers for the ray-march core.
// - fx_t       : signed Q(INT.FRAC) word at the default 24.8 format
// - state_e    : march sequencer states
// - fx_sat     : clamp a wide value into a w-bit signed range
// - fx_add_sat : saturating add in a w-bit signed range
// - fx_mul     : Q-format multiply, (a*b) >>> frac, saturated to w bits
// - is_hit / is_escaped : march termination tests
// - step_shade : 255 - (steps << shift), clamped at 0
// The helpers work on longint so that one set of functions serves every
// parametrised word width up to 32 bits.
package raymarch_pkg;

    localparam int unsigned FX_INT_BITS  = 24;
    localparam int unsigned FX_FRAC_BITS = 8;
    localparam int unsigned FX_W         = FX_INT_BITS + FX_FRAC_BITS;

    typedef logic signed [FX_W-1:0] fx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SQ,
        ST_SQRT,
        ST_STEP,
        ST_DONE
    } state_e;

    function automatic longint fx_sat(input longint v, input int unsigned w);
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (w - 1)) - 1;
        minv = -maxv - 1;
        if (v > maxv) return maxv;
        if (v < minv) return minv;
        return v;
    endfunction

    function automatic longint fx_add_sat(input longint a, input longint b,
                                          input int unsigned w);
        return fx_sat(a + b, w);
    endfunction

    function automatic longint fx_mul(input longint a, input longint b,
                                      input int unsigned frac, input int unsigned w);
        return fx_sat((a * b) >>> frac, w);
    endfunction

    function automatic logic is_hit(input longint sdf, input longint eps);
        return sdf < eps;
    endfunction

    function automatic logic is_escaped(input longint t, input longint max_dist);
        return t > max_dist;
    endfunction

    function automatic logic [7:0] step_shade(input int unsigned steps,
                                              input int unsigned shift);
        longint s;
        s = 64'sd255 - (longint'(steps) <<< shift);
        if (s < 0) s = 0;
        return s[7:0];
    endfunction

endpackage

// File: rtl/raymarch_fx_sqrt.sv
// Iterative restoring integer square root, one result bit per clock.
// - clk_i, rst_n_i : clock, asynchronous active-low reset
// - start_i        : load radicand_i; restarts any run in progress
// - radicand_i     : IN_W-bit unsigned operand (IN_W even)
// - done_o         : high from the cycle after the last bit until next start
// - root_o         : floor(sqrt(radicand)), IN_W/2 bits
// done_o rises IN_W/2 cycles after the cycle in which start_i is high.
module fx_sqrt #(
    parameter int unsigned IN_W = 40
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [IN_W-1:0]     radicand_i,
    output logic                done_o,
    output logic [IN_W/2-1:0]   root_o
);

    localparam int unsigned RW = IN_W / 2;
    localparam int unsigned CW = $clog2(RW) + 1;

    logic [IN_W-1:0] rad_q;
    logic [RW+1:0]   rem_q;
    logic [RW-1:0]   root_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;

    logic [RW+3:0]   rem_sh;
    logic [RW+3:0]   trial;
    logic [RW+3:0]   diff;
    logic            take;

    // Bring down the next two radicand bits and try subtracting 4*root+1.
    always_comb begin
        rem_sh = {rem_q, rad_q[IN_W-1 -: 2]};
        trial  = {2'b00, root_q, 2'b01};
        diff   = rem_sh - trial;
        take   = (rem_sh >= trial);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rad_q  <= radicand_i;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rad_q <= rad_q << 2;
            if (take) begin
                rem_q  <= diff[RW+1:0];
                root_q <= {root_q[RW-2:0], 1'b1};
            end else begin
                rem_q  <= rem_sh[RW+1:0];
                root_q <= {root_q[RW-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(RW - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done_o = done_q;
    assign root_o = root_q;

endmodule

// File: rtl/raymarch_core.sv
// Single-sphere signed-distance ray marcher: one pixel in, one RGB shade out.
// - clk_pixel_in, rst_n_in          : pixel clock, asynchronous active-low reset
// - in_valid/in_ready, curr_x/curr_y: pixel request handshake and coordinates
// - out_valid/out_ready             : result handshake (held under backpressure)
// - out_x/out_y                     : coordinates of the result pixel
// - red_out/green_out/blue_out      : shade (step-count shading on hit, BG on miss)
// - hit_out, steps_out              : hit flag and iterations evaluated
// Each march iteration is SQ (1) + SQRT ((W+FRAC_BITS)/2 + 1) + STEP (1) cycles.
// Word width W = INT_BITS + FRAC_BITS must not exceed 32.
module raymarch_core
    import raymarch_pkg::*;
#(
    parameter int unsigned WIDTH       = 300,
    parameter int unsigned HEIGHT      = 300,
    parameter int unsigned COORD_W     = 16,
    parameter int unsigned INT_BITS    = 24,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned MAX_STEPS   = 64,
    parameter int          HIT_EPS     = 16,
    parameter int          MAX_DIST    = 25600,
    parameter int          PIX_SCALE   = 1,
    parameter int          SPH_X       = 0,
    parameter int          SPH_Y       = 0,
    parameter int          SPH_Z       = 1280,
    parameter int          SPH_R       = 256,
    parameter int unsigned SHADE_SHIFT = 4,
    parameter logic [7:0]  BG_R        = 8'd0,
    parameter logic [7:0]  BG_G        = 8'd0,
    parameter logic [7:0]  BG_B        = 8'd0
) (
    input  logic                             clk_pixel_in,
    input  logic                             rst_n_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [COORD_W-1:0]               curr_x,
    input  logic [COORD_W-1:0]               curr_y,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [COORD_W-1:0]               out_x,
    output logic [COORD_W-1:0]               out_y,
    output logic [7:0]                       red_out,
    output logic [7:0]                       green_out,
    output logic [7:0]                       blue_out,
    output logic                             hit_out,
    output logic [$clog2(MAX_STEPS+1)-1:0]   steps_out
);

    localparam int unsigned W      = INT_BITS + FRAC_BITS;
    localparam int unsigned SQ_W   = W + FRAC_BITS;
    localparam int unsigned ROOT_W = SQ_W / 2;
    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

    state_e                 state_q;
    logic [COORD_W-1:0]     x_q, y_q;
    logic signed [W-1:0]    dx_q, dy_q, dz_q;
    logic signed [W-1:0]    px_q, py_q, pz_q;
    logic signed [W-1:0]    t_q, sdf_q;
    logic [STEP_W-1:0]      steps_q;
    logic                   start_q;
    logic                   in_ready_q, out_valid_q, hit_q;
    logic [COORD_W-1:0]     out_x_q, out_y_q;
    logic [7:0]             red_q, green_q, blue_q;
    logic [STEP_W-1:0]      steps_out_q;

    logic signed [W-1:0]    dx_d, dy_d, dz_d;
    logic signed [W-1:0]    magsq_d, sdf_d;
    logic signed [W-1:0]    px_d, py_d, pz_d, t_d;
    logic [STEP_W-1:0]      steps_d;
    logic                   hit_d, escape_d;
    logic [7:0]             shade_d;
    longint                 ex_l, ey_l, ez_l;
    logic [SQ_W-1:0]        radicand;
    logic [ROOT_W-1:0]      root;
    logic                   root_done;

    always_comb begin
        dx_d = W'(fx_sat((longint'(x_q) - longint'(WIDTH / 2)) * longint'(PIX_SCALE), W));
        dy_d = W'(fx_sat((longint'(y_q) - longint'(HEIGHT / 2)) * longint'(PIX_SCALE), W));
        dz_d = W'(longint'(1) <<< FRAC_BITS);

        ex_l = fx_add_sat(longint'(px_q), -longint'(SPH_X), W);
        ey_l = fx_add_sat(longint'(py_q), -longint'(SPH_Y), W);
        ez_l = fx_add_sat(longint'(pz_q), -longint'(SPH_Z), W);
        magsq_d = W'(fx_add_sat(fx_add_sat(fx_mul(ex_l, ex_l, FRAC_BITS, W),
                                           fx_mul(ey_l, ey_l, FRAC_BITS, W), W),
                                fx_mul(ez_l, ez_l, FRAC_BITS, W), W));
        // sqrt(magsq << FRAC) keeps the root in the same Q format as magsq.
        radicand = {magsq_d, {FRAC_BITS{1'b0}}};
        sdf_d    = W'(fx_add_sat(longint'(root), -longint'(SPH_R), W));

        // Half step along the ray: never overshoots the surface.
        px_d = W'(fx_add_sat(longint'(px_q),
                             fx_mul(longint'(dx_q), longint'(sdf_q), FRAC_BITS, W) >>> 1, W));
        py_d = W'(fx_add_sat(longint'(py_q),
                             fx_mul(longint'(dy_q), longint'(sdf_q), FRAC_BITS, W) >>> 1, W));
        pz_d = W'(fx_add_sat(longint'(pz_q),
                             fx_mul(longint'(dz_q), longint'(sdf_q), FRAC_BITS, W) >>> 1, W));
        t_d  = W'(fx_add_sat(longint'(t_q), longint'(sdf_q) >>> 1, W));

        steps_d  = steps_q + STEP_W'(1);
        hit_d    = is_hit(longint'(sdf_q), longint'(HIT_EPS));
        escape_d = is_escaped(longint'(t_d), longint'(MAX_DIST)) ||
                   (steps_d == STEP_W'(MAX_STEPS));
        shade_d  = step_shade(int'(steps_d), SHADE_SHIFT);
    end

    fx_sqrt #(
        .IN_W (SQ_W)
    ) u_sqrt (
        .clk_i      (clk_pixel_in),
        .rst_n_i    (rst_n_in),
        .start_i    (start_q),
        .radicand_i (radicand),
        .done_o     (root_done),
        .root_o     (root)
    );

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            dz_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            pz_q        <= '0;
            t_q         <= '0;
            sdf_q       <= '0;
            steps_q     <= '0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            steps_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        x_q        <= curr_x;
                        y_q        <= curr_y;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dx_q    <= dx_d;
                    dy_q    <= dy_d;
                    dz_q    <= dz_d;
                    px_q    <= '0;
                    py_q    <= '0;
                    pz_q    <= '0;
                    t_q     <= '0;
                    steps_q <= '0;
                    start_q <= 1'b1;
                    state_q <= ST_SQ;
                end
                ST_SQ: begin
                    // sqrt latches the radicand on this edge.
                    start_q <= 1'b0;
                    state_q <= ST_SQRT;
                end
                ST_SQRT: begin
                    if (root_done) begin
                        sdf_q   <= sdf_d;
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    steps_q <= steps_d;
                    if (hit_d || escape_d) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_x_q     <= x_q;
                        out_y_q     <= y_q;
                        hit_q       <= hit_d;
                        steps_out_q <= steps_d;
                        red_q       <= hit_d ? shade_d : BG_R;
                        green_q     <= hit_d ? shade_d : BG_G;
                        blue_q      <= hit_d ? shade_d : BG_B;
                    end else begin
                        start_q <= 1'b1;
                        state_q <= ST_SQ;
                    end
                    if (!hit_d) begin
                        px_q <= px_d;
                        py_q <= py_d;
                        pz_q <= pz_d;
                        t_q  <= t_d;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign red_out   = red_q;
    assign green_out = green_q;
    assign blue_out  = blue_q;
    assign hit_out   = hit_q;
    assign steps_out = steps_out_q;

endmodule

// File: tb/tb_raymarch_core.sv
module tb_raymarch_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready;
    logic [15:0] curr_x = '0, curr_y = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] out_x, out_y;
    logic [7:0]  red_out, green_out, blue_out;
    logic        hit_out;
    logic [6:0]  steps_out;

    logic        in_valid2 = 1'b0, in_ready2;
    logic [15:0] curr_x2 = '0, curr_y2 = '0;
    logic        out_valid2, out_ready2 = 1'b1;
    logic [15:0] out_x2, out_y2;
    logic [7:0]  red2, green2, blue2;
    logic        hit2;
    logic [2:0]  steps2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    raymarch_core u_dut (
        .clk_pixel_in (clk),
        .rst_n_in     (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .curr_x       (curr_x),
        .curr_y       (curr_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .red_out      (red_out),
        .green_out    (green_out),
        .blue_out     (blue_out),
        .hit_out      (hit_out),
        .steps_out    (steps_out)
    );

    raymarch_core #(
        .MAX_STEPS (4)
    ) u_dut4 (
        .clk_pixel_in (clk),
        .rst_n_in     (rst_n),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .curr_x       (curr_x2),
        .curr_y       (curr_y2),
        .out_valid    (out_valid2),
        .out_ready    (out_ready2),
        .out_x        (out_x2),
        .out_y        (out_y2),
        .red_out      (red2),
        .green_out    (green2),
        .blue_out     (blue2),
        .hit_out      (hit2),
        .steps_out    (steps2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 1000) begin
            tick();
            n++;
        end
        check("ready_wait", in_ready, 1);
        in_valid = 1'b1;
        curr_x   = x;
        curr_y   = y;
        tick();
        in_valid = 1'b0;
    endtask

    // Call right after the accept edge (+1); returns cycles to out_valid.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 3000) begin
            tick();
            lat++;
        end
        check("result_seen", out_valid, 1);
    endtask

    initial begin
        int lat;
        int bad;

        // Reset state
        tick(); tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_red", red_out, 0);
        check("rst_hit", hit_out, 0);
        check("rst_steps", steps_out, 0);
        check("rst_out_x", out_x, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Centre pixel: 8 steps, hit, shade 255-128
        send(16'd150, 16'd150);
        check("busy_in_ready", in_ready, 0);
        wait_result(lat);
        check("centre_latency", lat, 185);
        check("centre_hit", hit_out, 1);
        check("centre_steps", steps_out, 8);
        check("centre_red", red_out, 127);
        check("centre_green", green_out, 127);
        check("centre_blue", blue_out, 127);
        check("centre_x", out_x, 150);
        check("centre_y", out_y, 150);
        tick();
        check("centre_xfer_valid", out_valid, 0);
        check("centre_xfer_ready", in_ready, 1);

        // Corner pixel: ray misses the sphere
        send(16'd0, 16'd0);
        wait_result(lat);
        check("corner_hit", hit_out, 0);
        check("corner_red", red_out, 0);
        check("corner_green", green_out, 0);
        check("corner_blue", blue_out, 0);
        check("corner_steps_range", (steps_out >= 1 && steps_out <= 64), 1);
        check("corner_x", out_x, 0);
        tick();

        // Backpressure: result held for 50 cycles
        out_ready = 1'b0;
        send(16'd150, 16'd150);
        wait_result(lat);
        check("bp_latency", lat, 185);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || hit_out !== 1'b1 ||
                steps_out !== 7'd8 || red_out !== 8'd127 || green_out !== 8'd127 ||
                blue_out !== 8'd127 || out_x !== 16'd150 || out_y !== 16'd150)
                bad++;
            tick();
        end
        check("bp_hold_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        check("bp_xfer_valid", out_valid, 0);
        check("bp_xfer_ready", in_ready, 1);

        // Back-to-back with in_valid held high
        curr_x   = 16'd150;
        curr_y   = 16'd150;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("b2b_accepted", in_ready, 0);
            wait_result(lat);
            check("b2b_latency", lat, 185);
            check("b2b_steps", steps_out, 8);
            tick();
            check("b2b_idle_gap", {out_valid, in_ready}, 2'b01);
            if (k == 9) in_valid = 1'b0;
        end

        // Reset pulse mid-march
        send(16'd150, 16'd150);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) bad++;
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("midrst_in_ready", in_ready, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) bad++;
            tick();
        end
        check("midrst_no_valid", bad, 0);
        check("midrst_ready", in_ready, 1);
        send(16'd150, 16'd150);
        wait_result(lat);
        check("midrst_latency", lat, 185);
        check("midrst_hit", hit_out, 1);
        check("midrst_red", red_out, 127);
        tick();

        // Step limit 4 on the second instance
        check("lim_ready", in_ready2, 1);
        in_valid2 = 1'b1;
        curr_x2   = 16'd150;
        curr_y2   = 16'd150;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 1000) begin
            tick();
            lat++;
        end
        check("lim_seen", out_valid2, 1);
        check("lim_latency", lat, 93);
        check("lim_hit", hit2, 0);
        check("lim_steps", steps2, 4);
        check("lim_red", red2, 0);
        check("lim_green", green2, 0);
        check("lim_blue", blue2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
